jelly_axi4l_peri_register_bank: RTL and testbench
=================================================

Name: jelly_axi4l_peri_register_bank

Overview:
- AXI4-Lite slave register bank on the PS peripheral master port (m_axi4l_peri, 100 MHz domain).
- Directly downstream of the PS block design: consumes its AXI4-Lite master transactions.
- Exposes REG_NUM read/write control registers to fabric logic, plus a one-cycle write strobe per register.
- Used as the control/status front end of the fabric cores.

Parameters:
- AXI4L_ADDR_WIDTH, 32: AXI4-Lite address width.
- AXI4L_DATA_WIDTH, 32: data width; must be 32 or 64.
- REG_NUM, 16: number of registers (1..256).
- REG_BASE, 32'h0000_0000: byte address of register 0; aligned to the data width.
- INIT_VALUE, 0: reset value loaded into every register.

Ports:
- reset  input  1  asynchronous, active-high reset.
- clk  input  1  peripheral bus clock (m_axi4l_peri_aclk).
- s_axi4l_awaddr  input  AXI4L_ADDR_WIDTH  write address.
- s_axi4l_awprot  input  3  ignored.
- s_axi4l_awvalid / s_axi4l_awready  input / output  1  AW handshake.
- s_axi4l_wdata  input  AXI4L_DATA_WIDTH  write data.
- s_axi4l_wstrb  input  AXI4L_DATA_WIDTH/8  byte enables.
- s_axi4l_wvalid / s_axi4l_wready  input / output  1  W handshake.
- s_axi4l_bresp  output  2  write response.
- s_axi4l_bvalid / s_axi4l_bready  output / input  1  B handshake.
- s_axi4l_araddr  input  AXI4L_ADDR_WIDTH  read address.
- s_axi4l_arprot  input  3  ignored.
- s_axi4l_arvalid / s_axi4l_arready  input / output  1  AR handshake.
- s_axi4l_rdata  output  AXI4L_DATA_WIDTH  read data.
- s_axi4l_rresp  output  2  read response.
- s_axi4l_rvalid / s_axi4l_rready  output / input  1  R handshake.
- out_regs  output  REG_NUM*AXI4L_DATA_WIDTH  register contents; register i occupies bits [i*W +: W].
- out_wr_stb  output  REG_NUM  one-cycle pulse per written register.

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - awready = wready = arready = 0 while reset is asserted; they go to 1 on the first clk edge after release.
  - bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0.
  - out_regs = INIT_VALUE for every register; out_wr_stb = 0.
  - AW and W holding buffers are empty.
- Address decode:
  - idx = (addr - REG_BASE) >> log2(AXI4L_DATA_WIDTH/8). Low byte-offset bits are ignored.
  - The address is in range when addr >= REG_BASE and idx < REG_NUM.
- Write channel (one outstanding write maximum):
  - AW and W are captured independently into one-entry buffers, in either order or in the same cycle.
  - awready = !aw_full && !bvalid. wready = !w_full && !bvalid.
  - Let edge E be the edge at which the later of the two handshakes completes.
  - At edge E+1: the addressed register updates byte-wise per wstrb, both buffers clear, and bvalid rises.
  - During the cycle after edge E+1: out_wr_stb[idx] = 1, for exactly one cycle. It is pulsed even if wstrb = 0.
  - bvalid holds until bready is sampled high. awready and wready stay low while bvalid = 1.
  - bresp = 2'b00 (OKAY).
  - Out-of-range write: no register changes, no strobe, bvalid still issues.
- Read channel:
  - arready = !rvalid.
  - At the AR handshake edge E: rdata is registered from the register value as it stands before edge E, rvalid is set, and rresp = OKAY.
  - rdata and rvalid hold stable until rready is sampled high. Read latency is 1 cycle; sustained throughput is 1 read per 2 cycles.
  - Out-of-range read: rdata = 0.
- Simultaneous events:
  - A read and a write commit to the same register at the same edge: the read returns the old value.
  - Read and write channels run fully in parallel.
- Reset mid-transaction:
  - All buffers and handshakes are dropped immediately. Pending B or R responses are discarded, and registers return to INIT_VALUE.

Optional Feature:
- Macro: JELLY_AXI4L_PERI_REGISTER_BANK_SLVERR_EN.
- Defined:
  - Out-of-range write returns bresp = 2'b10 (SLVERR).
  - Out-of-range read returns rresp = 2'b10 and rdata = 0.
  - In-range accesses return OKAY.
- Undefined: every response is OKAY, and the SLVERR decode logic is not built.

Test Plan:
- Reset: assert reset mid-cycle (asynchronous) -> out_regs all INIT_VALUE, bvalid = rvalid = 0 immediately; awready, wready and arready go to 1 one edge after release.
- Full write then read-back: write 32'hDEADBEEF, wstrb 4'hF to REG_BASE+0xC -> register 3 = DEADBEEF, out_wr_stb = 16'h0008 for 1 cycle, bresp = 0. Read the same address -> rdata = DEADBEEF one cycle after the AR handshake.
- Partial write: register 3 = DEADBEEF, write 32'h12345678 with wstrb 4'h3 -> register 3 = DEAD5678.
- Channel order and backpressure:
  - Present AW 3 cycles before W, with bready held low for 5 cycles -> no update until W arrives.
  - bvalid stays high and awready/wready stay low throughout.
  - A second write is accepted only after the B handshake.
- Out-of-range access at REG_BASE+0x40 (REG_NUM = 16):
  - With the macro defined: bresp = 2, rresp = 2, rdata = 0.
  - Without the macro: both responses 0, rdata = 0.
  - In both builds, no register changes and no strobe fires.
- Read/write collision: a read of register 5 (= 1) is accepted on the same edge that a write of 2 to register 5 commits -> rdata = 1; a subsequent read returns 2.

Source files
------------

// File: rtl/jelly_axi4l_peri_register_bank.sv
// AXI4-Lite slave register bank with per-register write strobes.
// Optional SLVERR responses: JELLY_AXI4L_PERI_REGISTER_BANK_SLVERR_EN.
module jelly_axi4l_peri_register_bank #(
  parameter int AXI4L_ADDR_WIDTH = 32,
  parameter int AXI4L_DATA_WIDTH = 32,
  parameter int REG_NUM = 16,
  parameter logic [AXI4L_ADDR_WIDTH-1:0] REG_BASE = '0,
  parameter logic [AXI4L_DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                                  reset,
  input  logic                                  clk,
  input  logic [AXI4L_ADDR_WIDTH-1:0]           s_axi4l_awaddr,
  input  logic [2:0]                            s_axi4l_awprot,
  input  logic                                  s_axi4l_awvalid,
  output logic                                  s_axi4l_awready,
  input  logic [AXI4L_DATA_WIDTH-1:0]           s_axi4l_wdata,
  input  logic [AXI4L_DATA_WIDTH/8-1:0]         s_axi4l_wstrb,
  input  logic                                  s_axi4l_wvalid,
  output logic                                  s_axi4l_wready,
  output logic [1:0]                            s_axi4l_bresp,
  output logic                                  s_axi4l_bvalid,
  input  logic                                  s_axi4l_bready,
  input  logic [AXI4L_ADDR_WIDTH-1:0]           s_axi4l_araddr,
  input  logic [2:0]                            s_axi4l_arprot,
  input  logic                                  s_axi4l_arvalid,
  output logic                                  s_axi4l_arready,
  output logic [AXI4L_DATA_WIDTH-1:0]           s_axi4l_rdata,
  output logic [1:0]                            s_axi4l_rresp,
  output logic                                  s_axi4l_rvalid,
  input  logic                                  s_axi4l_rready,
  output logic [REG_NUM*AXI4L_DATA_WIDTH-1:0]   out_regs,
  output logic [REG_NUM-1:0]                    out_wr_stb
);

  localparam int AW       = AXI4L_ADDR_WIDTH;
  localparam int DW       = AXI4L_DATA_WIDTH;
  localparam int STRB_W   = DW / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [AW-1:0] REG_NUM_A = AW'(REG_NUM);

  logic              rdy_q, rdy_d;
  logic              aw_full_q, aw_full_d;
  logic [AW-1:0]     aw_addr_q, aw_addr_d;
  logic              w_full_q, w_full_d;
  logic [DW-1:0]     w_data_q, w_data_d;
  logic [STRB_W-1:0] w_strb_q, w_strb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [DW-1:0]     regs_q [REG_NUM];
  logic [DW-1:0]     regs_d [REG_NUM];
  logic [REG_NUM-1:0] wr_stb_q, wr_stb_d;

  logic              aw_hs, w_hs, ar_hs, commit;
  logic [AW-1:0]     wr_off, wr_word, rd_off, rd_word;
  logic              wr_hit, rd_hit;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              unused_ok;

  assign unused_ok = ^{s_axi4l_awprot, s_axi4l_arprot};

  // Address decode for the buffered write and the incoming read.
  always_comb begin
    wr_off  = aw_addr_q - REG_BASE;
    wr_word = wr_off >> ADDR_LSB;
    wr_hit  = (aw_addr_q >= REG_BASE) && (wr_word < REG_NUM_A);
    wr_idx  = wr_word[IDX_W-1:0];
    rd_off  = s_axi4l_araddr - REG_BASE;
    rd_word = rd_off >> ADDR_LSB;
    rd_hit  = (s_axi4l_araddr >= REG_BASE) && (rd_word < REG_NUM_A);
    rd_idx  = rd_word[IDX_W-1:0];
  end

  assign s_axi4l_awready = rdy_q && !aw_full_q && !bvalid_q;
  assign s_axi4l_wready  = rdy_q && !w_full_q && !bvalid_q;
  assign s_axi4l_arready = rdy_q && !rvalid_q;

  assign aw_hs  = s_axi4l_awvalid && s_axi4l_awready;
  assign w_hs   = s_axi4l_wvalid && s_axi4l_wready;
  assign ar_hs  = s_axi4l_arvalid && s_axi4l_arready;
  assign commit = aw_full_q && w_full_q && !bvalid_q;

  // Write path: buffer AW/W, commit one cycle after both are held.
  always_comb begin
    rdy_d     = 1'b1;
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    wr_stb_d  = '0;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_axi4l_awaddr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s_axi4l_wdata;
      w_strb_d = s_axi4l_wstrb;
    end
    if (bvalid_q && s_axi4l_bready) begin
      bvalid_d = 1'b0;
    end
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
`ifdef JELLY_AXI4L_PERI_REGISTER_BANK_SLVERR_EN
      bresp_d   = wr_hit ? 2'b00 : 2'b10;
`else
      bresp_d   = 2'b00;
`endif
      if (wr_hit) begin
        wr_stb_d[wr_idx] = 1'b1;
        for (int b = 0; b < STRB_W; b++) begin
          if (w_strb_q[b]) begin
            regs_d[wr_idx][b*8 +: 8] = w_data_q[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read path: capture register value at the AR handshake.
  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rvalid_q && s_axi4l_rready) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_hit ? regs_q[rd_idx] : '0;
`ifdef JELLY_AXI4L_PERI_REGISTER_BANK_SLVERR_EN
      rresp_d  = rd_hit ? 2'b00 : 2'b10;
`else
      rresp_d  = 2'b00;
`endif
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q     <= 1'b0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      regs_q    <= '{default: INIT_VALUE};
      wr_stb_q  <= '0;
    end else begin
      rdy_q     <= rdy_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
      wr_stb_q  <= wr_stb_d;
    end
  end

  // Flatten the register array onto the output bus.
  always_comb begin
    out_regs = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      out_regs[i*DW +: DW] = regs_q[i];
    end
  end

  assign out_wr_stb     = wr_stb_q;
  assign s_axi4l_bvalid = bvalid_q;
  assign s_axi4l_bresp  = bresp_q;
  assign s_axi4l_rvalid = rvalid_q;
  assign s_axi4l_rresp  = rresp_q;
  assign s_axi4l_rdata  = rdata_q;

endmodule

// File: tb/tb_jelly_axi4l_peri_register_bank.sv
// Directed testbench for jelly_axi4l_peri_register_bank.
// Drives and samples on the falling clock edge.
module tb_jelly_axi4l_peri_register_bank;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int N = 16;
`ifdef JELLY_AXI4L_PERI_REGISTER_BANK_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic          reset, clk;
  logic [31:0]   awaddr, wdata, araddr, rdata;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, arvalid, arready, rvalid, rready;
  logic [N*32-1:0] out_regs;
  logic [N-1:0]  out_wr_stb;

  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] mdl [N];
  logic [31:0] rd_d;
  logic [1:0]  rsp;
  logic [15:0] stb;

  jelly_axi4l_peri_register_bank #(
    .AXI4L_ADDR_WIDTH(32),
    .AXI4L_DATA_WIDTH(32),
    .REG_NUM(N),
    .REG_BASE(BASE),
    .INIT_VALUE(32'h0)
  ) dut (
    .reset(reset),
    .clk(clk),
    .s_axi4l_awaddr(awaddr),
    .s_axi4l_awprot(awprot),
    .s_axi4l_awvalid(awvalid),
    .s_axi4l_awready(awready),
    .s_axi4l_wdata(wdata),
    .s_axi4l_wstrb(wstrb),
    .s_axi4l_wvalid(wvalid),
    .s_axi4l_wready(wready),
    .s_axi4l_bresp(bresp),
    .s_axi4l_bvalid(bvalid),
    .s_axi4l_bready(bready),
    .s_axi4l_araddr(araddr),
    .s_axi4l_arprot(arprot),
    .s_axi4l_arvalid(arvalid),
    .s_axi4l_arready(arready),
    .s_axi4l_rdata(rdata),
    .s_axi4l_rresp(rresp),
    .s_axi4l_rvalid(rvalid),
    .s_axi4l_rready(rready),
    .out_regs(out_regs),
    .out_wr_stb(out_wr_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*32-1:0] exp_regs();
    logic [N*32-1:0] v;
    for (int i = 0; i < N; i++) v[i*32 +: 32] = mdl[i];
    return v;
  endfunction

  function automatic logic [31:0] reg_of(input int i);
    return out_regs[i*32 +: 32];
  endfunction

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] r,
                           output logic [15:0] sb);
    bit aw_done, w_done, a_rdy, w_rdy;
    int k;
    aw_done = 0;
    w_done = 0;
    awaddr = a;
    wdata = d;
    wstrb = s;
    awvalid = 1'b1;
    wvalid = 1'b1;
    bready = 1'b1;
    k = 0;
    while (!(aw_done && w_done) && k < 20) begin
      a_rdy = awready;
      w_rdy = wready;
      @(negedge clk);
      k++;
      if (a_rdy && awvalid) begin awvalid = 1'b0; aw_done = 1; end
      if (w_rdy && wvalid) begin wvalid = 1'b0; w_done = 1; end
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    k = 0;
    while (!bvalid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("wr_bvalid_timeout", bvalid, 1'b1);
    r = bresp;
    sb = out_wr_stb;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] r);
    bit done, a_rdy;
    int k;
    done = 0;
    araddr = a;
    arvalid = 1'b1;
    rready = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      a_rdy = arready;
      @(negedge clk);
      k++;
      if (a_rdy) begin arvalid = 1'b0; done = 1; end
    end
    arvalid = 1'b0;
    check("rd_latency", rvalid, 1'b1);
    d = rdata;
    r = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("rd_rvalid_drop", rvalid, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < N; i++) mdl[i] = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", awready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_regs", out_regs, exp_regs());
    check("rst_stb", out_wr_stb, 16'h0);
    reset = 1'b0;
    #1;
    check("rel_awready_low", awready, 1'b0);
    @(negedge clk);
    check("rel_awready", awready, 1'b1);
    check("rel_wready", wready, 1'b1);
    check("rel_arready", arready, 1'b1);

    // Full write, cycle by cycle
    awaddr = BASE + 32'hC;
    wdata = 32'hDEADBEEF;
    wstrb = 4'hF;
    awvalid = 1'b1;
    wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b0;
    check("fw_e_bvalid", bvalid, 1'b0);
    check("fw_e_reg3", reg_of(3), 32'h0);
    check("fw_e_stb", out_wr_stb, 16'h0);
    @(negedge clk);
    mdl[3] = 32'hDEADBEEF;
    check("fw_regs", out_regs, exp_regs());
    check("fw_stb", out_wr_stb, 16'h0008);
    check("fw_bvalid", bvalid, 1'b1);
    check("fw_bresp", bresp, 2'b00);
    check("fw_awready_low", awready, 1'b0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("fw_b_done", bvalid, 1'b0);
    check("fw_stb_once", out_wr_stb, 16'h0);
    check("fw_awready_back", awready, 1'b1);
    axi_read(BASE + 32'hC, rd_d, rsp);
    check("rb_rdata", rd_d, 32'hDEADBEEF);
    check("rb_rresp", rsp, 2'b00);

    // Partial write
    axi_write(BASE + 32'hC, 32'h12345678, 4'h3, rsp, stb);
    mdl[3] = 32'hDEAD5678;
    check("pw_bresp", rsp, 2'b00);
    check("pw_stb", stb, 16'h0008);
    check("pw_regs", out_regs, exp_regs());

    // AW three cycles before W, then B backpressure
    awaddr = BASE + 32'h1C;
    wdata = 32'hA5A50007;
    wstrb = 4'hF;
    awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("ord_awready_low", awready, 1'b0);
      check("ord_wready", wready, 1'b1);
      check("ord_no_b", bvalid, 1'b0);
      check("ord_no_upd", out_regs, exp_regs());
      @(negedge clk);
    end
    wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("ord_pre_b", bvalid, 1'b0);
    check("ord_pre_upd", out_regs, exp_regs());
    @(negedge clk);
    mdl[7] = 32'hA5A50007;
    check("ord_regs", out_regs, exp_regs());
    check("ord_stb", out_wr_stb, 16'h0080);
    awaddr = BASE + 32'h20;
    wdata = 32'h0000_0888;
    awvalid = 1'b1;
    wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid", bvalid, 1'b1);
      check("bp_awready", awready, 1'b0);
      check("bp_wready", wready, 1'b0);
      @(negedge clk);
      if (i == 0) check("bp_stb_clear", out_wr_stb, 16'h0);
    end
    check("bp_reg8_hold", reg_of(8), 32'h0);
    bready = 1'b1;
    @(negedge clk);
    check("bp_b_done", bvalid, 1'b0);
    check("bp_awready_back", awready, 1'b1);
    check("bp_wready_back", wready, 1'b1);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b0;
    check("w2_pre_b", bvalid, 1'b0);
    @(negedge clk);
    mdl[8] = 32'h0000_0888;
    check("w2_bvalid", bvalid, 1'b1);
    check("w2_stb", out_wr_stb, 16'h0100);
    check("w2_regs", out_regs, exp_regs());
    @(negedge clk);
    bready = 1'b0;

    // Last register and byte-offset bits
    axi_write(BASE + 32'h3C, 32'hCAFE_F00D, 4'hF, rsp, stb);
    mdl[15] = 32'hCAFE_F00D;
    check("last_stb", stb, 16'h8000);
    check("last_regs", out_regs, exp_regs());
    axi_read(BASE + 32'h1F, rd_d, rsp);
    check("lsb_ignored", rd_d, 32'hA5A50007);
    axi_read(BASE + 32'h3C, rd_d, rsp);
    check("last_rd", rd_d, 32'hCAFE_F00D);

    // Out of range: above and below the window
    axi_write(BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, rsp, stb);
    check("oor_bresp", rsp, OOR_RESP);
    check("oor_stb", stb, 16'h0);
    check("oor_regs", out_regs, exp_regs());
    axi_read(BASE + 32'h40, rd_d, rsp);
    check("oor_rdata", rd_d, 32'h0);
    check("oor_rresp", rsp, OOR_RESP);
    axi_write(BASE - 32'h4, 32'h1111_1111, 4'hF, rsp, stb);
    check("below_bresp", rsp, OOR_RESP);
    check("below_stb", stb, 16'h0);
    check("below_regs", out_regs, exp_regs());
    axi_read(BASE - 32'h4, rd_d, rsp);
    check("below_rdata", rd_d, 32'h0);
    check("below_rresp", rsp, OOR_RESP);

    // Read/write collision on register 5
    axi_write(BASE + 32'h14, 32'h1, 4'hF, rsp, stb);
    mdl[5] = 32'h1;
    awaddr = BASE + 32'h14;
    wdata = 32'h2;
    wstrb = 4'hF;
    awvalid = 1'b1;
    wvalid = 1'b1;
    bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b0;
    araddr = BASE + 32'h14;
    arvalid = 1'b1;
    check("col_arready", arready, 1'b1);
    check("col_pre_b", bvalid, 1'b0);
    @(negedge clk);
    arvalid = 1'b0;
    mdl[5] = 32'h2;
    check("col_rvalid", rvalid, 1'b1);
    check("col_rdata_old", rdata, 32'h1);
    check("col_bvalid", bvalid, 1'b1);
    check("col_regs", out_regs, exp_regs());
    rready = 1'b1;
    bready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    bready = 1'b0;
    check("col_r_done", rvalid, 1'b0);
    check("col_b_done", bvalid, 1'b0);
    axi_read(BASE + 32'h14, rd_d, rsp);
    check("col_rdata_new", rd_d, 32'h2);

    // Asynchronous reset with B and R pending
    awaddr = BASE + 32'h8;
    wdata = 32'h0000_0BAD;
    awvalid = 1'b1;
    wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b0;
    araddr = BASE + 32'hC;
    arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    check("ar_pend_b", bvalid, 1'b1);
    check("ar_pend_r", rvalid, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) mdl[i] = 32'h0;
    check("ar_bvalid", bvalid, 1'b0);
    check("ar_rvalid", rvalid, 1'b0);
    check("ar_regs", out_regs, exp_regs());
    check("ar_rdata", rdata, 32'h0);
    check("ar_awready", awready, 1'b0);
    check("ar_arready", arready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ar_rel_low", wready, 1'b0);
    @(negedge clk);
    check("ar_rel_awready", awready, 1'b1);
    check("ar_rel_wready", wready, 1'b1);
    check("ar_rel_arready", arready, 1'b1);
    check("ar_rel_stb", out_wr_stb, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
